// File: rtl/dla_gb2lb_mov_ctrl_pkg.sv
// PKG_dla_regmap: shared register-map types for the DLA GB->LB move engine.
// Holds the move-controller FSM state encoding and the GB2LB staging
// register layout, plus the field widths used by the controller and its
// address generators.
package PKG_dla_regmap;

    localparam int GB_AW  = 13;   // GB address width
    localparam int LB_AW  = 11;   // LB address width
    localparam int GB_SKW = 13;   // GB stride width
    localparam int LB_SKW = 6;    // LB stride width
    localparam int LEN_W  = 13;   // words per iteration
    localparam int ITER_W = 6;    // iteration count
    localparam int BEAT_W = 19;   // total beats, covers 8191*63

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } gb2lb_state_e;

    typedef struct packed {
        logic [GB_AW-1:0]  gb_addr;
        logic [GB_SKW-1:0] gb_skip;
        logic [LB_AW-1:0]  lb_addr;
        logic [LB_SKW-1:0] lb_skip;
        logic [LEN_W-1:0]  len;
        logic [ITER_W-1:0] iter;
    } gb2lb_cfg_t;

    // A move with no words or no iterations completes without any traffic.
    function automatic logic cfg_empty(input gb2lb_cfg_t c);
        return (c.len == '0) || (c.iter == '0);
    endfunction

endpackage

// File: rtl/dla_gb2lb_addr_gen.sv
// dla_gb2lb_addr_gen: strided 2-D address walker.
// Produces (base + i*skip + j) mod 2^AW for j in [0,len), i in [0,iter)
// using an accumulator, no multiplier.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   base, skip       start address and per-iteration stride
//   len, iter        words per iteration, iteration count
//   load             restart the walk at base
//   step             advance to the next word
//   addr             address of the current word (registered)
//   last             current word is the final word of the walk
module dla_gb2lb_addr_gen
    import PKG_dla_regmap::*;
#(
    parameter int AW  = 13,
    parameter int SKW = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     base,
    input  logic [SKW-1:0]    skip,
    input  logic [LEN_W-1:0]  len,
    input  logic [ITER_W-1:0] iter,
    input  logic              load,
    input  logic              step,
    output logic [AW-1:0]     addr,
    output logic              last
);

    logic [LEN_W-1:0]  j_q;
    logic [ITER_W-1:0] i_q;
    logic [AW-1:0]     row_q;      // address of word 0 of the current row
    logic [AW-1:0]     skip_ext;
    logic [AW-1:0]     row_nxt;
    logic              row_end;

    assign skip_ext = AW'(skip);
    assign row_nxt  = row_q + skip_ext;
    assign row_end  = (j_q == len - LEN_W'(1));
    assign last     = row_end && (i_q == iter - ITER_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q   <= '0;
            i_q   <= '0;
            row_q <= '0;
            addr  <= '0;
        end else if (load) begin
            j_q   <= '0;
            i_q   <= '0;
            row_q <= base;
            addr  <= base;
        end else if (step) begin
            if (row_end) begin
                j_q   <= '0;
                i_q   <= i_q + ITER_W'(1);
                row_q <= row_nxt;
                addr  <= row_nxt;
            end else begin
                j_q  <= j_q + LEN_W'(1);
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/dla_gb2lb_mov_ctrl.sv
// dla_gb2lb_mov_ctrl: moves len*iter words from the global buffer (GB) to
// the local buffer (LB) with independent strides on both sides.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   go_mov_gb2lb          start pulse (ignored and flagged unless IDLE)
//   stgr_gb2lb_*          staging registers, sampled in LOAD
//   gb_rd_req/addr/gnt    GB read request channel
//   gb_rvld/gb_rdata      GB in-order read return
//   lb_wen/waddr/wdata    LB write port, one cycle after each GB return
//   mov_busy/done/go_err  status
module dla_gb2lb_mov_ctrl
    import PKG_dla_regmap::*;
#(
    parameter int DW       = 64,
    parameter int MAX_OUTS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_mov_gb2lb,
    input  logic [GB_AW-1:0]  stgr_gb2lb_gb_addr,
    input  logic [GB_SKW-1:0] stgr_gb2lb_gb_skip,
    input  logic [LB_AW-1:0]  stgr_gb2lb_lb_addr,
    input  logic [LB_SKW-1:0] stgr_gb2lb_lb_skip,
    input  logic [LEN_W-1:0]  stgr_gb2lb_len,
    input  logic [ITER_W-1:0] stgr_gb2lb_iter,
    output logic              gb_rd_req,
    output logic [GB_AW-1:0]  gb_rd_addr,
    input  logic              gb_rd_gnt,
    input  logic              gb_rvld,
    input  logic [DW-1:0]     gb_rdata,
    output logic              lb_wen,
    output logic [LB_AW-1:0]  lb_waddr,
    output logic [DW-1:0]     lb_wdata,
    output logic              mov_busy,
    output logic              mov_done,
    output logic              mov_go_err
);

    localparam int OW = $clog2(MAX_OUTS + 1);

    gb2lb_state_e state_q, state_d;
    gb2lb_cfg_t   stgr_cfg, cfg_q, cfg_sel;

    logic [OW-1:0]     outs_q;
    logic [BEAT_W-1:0] rd_beats_q, wr_beats_q;
    logic              wr_all_q;     // final write beat has been scheduled
    logic              load, rd_hs, rvld_ok, rd_last, wr_last;
    logic [LB_AW-1:0]  wr_addr;

    assign stgr_cfg = '{gb_addr: stgr_gb2lb_gb_addr, gb_skip: stgr_gb2lb_gb_skip,
                        lb_addr: stgr_gb2lb_lb_addr, lb_skip: stgr_gb2lb_lb_skip,
                        len:     stgr_gb2lb_len,     iter:    stgr_gb2lb_iter};

    // The address walkers restart in LOAD from the staging values, while the
    // working copy is being captured; afterwards they run off the working copy.
    assign load    = (state_q == LOAD);
    assign cfg_sel = load ? stgr_cfg : cfg_q;

    assign gb_rd_req = (state_q == RUN) && (outs_q < OW'(MAX_OUTS));
    assign rd_hs     = gb_rd_req && gb_rd_gnt;
    // Returns with nothing outstanding are stale (e.g. from before a reset).
    assign rvld_ok   = gb_rvld && (outs_q != '0);

    assign mov_busy = (state_q != IDLE);
    assign mov_done = (state_q == DONE);

    dla_gb2lb_addr_gen #(.AW(GB_AW), .SKW(GB_SKW)) u_rd_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .base  (cfg_sel.gb_addr),
        .skip  (cfg_sel.gb_skip),
        .len   (cfg_sel.len),
        .iter  (cfg_sel.iter),
        .load  (load),
        .step  (rd_hs),
        .addr  (gb_rd_addr),
        .last  (rd_last)
    );

    dla_gb2lb_addr_gen #(.AW(LB_AW), .SKW(LB_SKW)) u_wr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .base  (cfg_sel.lb_addr),
        .skip  (cfg_sel.lb_skip),
        .len   (cfg_sel.len),
        .iter  (cfg_sel.iter),
        .load  (load),
        .step  (rvld_ok),
        .addr  (wr_addr),
        .last  (wr_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (go_mov_gb2lb) state_d = LOAD;
            LOAD:  state_d = cfg_empty(cfg_sel) ? DONE : RUN;
            RUN:   if (rd_hs && rd_last) state_d = DRAIN;
            DRAIN: if (wr_all_q && (outs_q == '0) && (wr_beats_q == rd_beats_q))
                       state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            outs_q     <= '0;
            rd_beats_q <= '0;
            wr_beats_q <= '0;
            wr_all_q   <= 1'b0;
            lb_wen     <= 1'b0;
            lb_waddr   <= '0;
            lb_wdata   <= '0;
            mov_go_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cfg_q      <= stgr_cfg;
                outs_q     <= '0;
                rd_beats_q <= '0;
                wr_beats_q <= '0;
                wr_all_q   <= 1'b0;
            end else begin
                unique case ({rd_hs, rvld_ok})
                    2'b10:   outs_q <= outs_q + OW'(1);
                    2'b01:   outs_q <= outs_q - OW'(1);
                    default: outs_q <= outs_q;
                endcase
                if (rd_hs) rd_beats_q <= rd_beats_q + BEAT_W'(1);
                if (rvld_ok) begin
                    wr_beats_q <= wr_beats_q + BEAT_W'(1);
                    if (wr_last) wr_all_q <= 1'b1;
                end
            end
            lb_wen <= rvld_ok;
            if (rvld_ok) begin
                lb_waddr <= wr_addr;
                lb_wdata <= gb_rdata;
            end
            mov_go_err <= go_mov_gb2lb && (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_dla_gb2lb_mov_ctrl.sv
// Directed bench for dla_gb2lb_mov_ctrl: GB responder with programmable
// latency, LB/GB traffic logging, and hand-computed expectations.
module tb_dla_gb2lb_mov_ctrl;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [12:0]   s_ga = '0, s_gs = '0, s_len = '0;
    logic [10:0]   s_la = '0;
    logic [5:0]    s_ls = '0, s_it = '0;
    logic          gnt = 1'b1;
    logic          stray = 1'b0;
    logic          m_rvld = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    logic          gb_rd_req, lb_wen, mov_busy, mov_done, mov_go_err, gb_rvld;
    logic [12:0]   gb_rd_addr;
    logic [10:0]   lb_waddr;
    logic [DW-1:0] lb_wdata, gb_rdata;

    assign gb_rvld  = m_rvld | stray;
    assign gb_rdata = m_rdata;

    always #5 clk = ~clk;

    dla_gb2lb_mov_ctrl #(.DW(DW), .MAX_OUTS(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .go_mov_gb2lb       (go),
        .stgr_gb2lb_gb_addr (s_ga),
        .stgr_gb2lb_gb_skip (s_gs),
        .stgr_gb2lb_lb_addr (s_la),
        .stgr_gb2lb_lb_skip (s_ls),
        .stgr_gb2lb_len     (s_len),
        .stgr_gb2lb_iter    (s_it),
        .gb_rd_req          (gb_rd_req),
        .gb_rd_addr         (gb_rd_addr),
        .gb_rd_gnt          (gnt),
        .gb_rvld            (gb_rvld),
        .gb_rdata           (gb_rdata),
        .lb_wen             (lb_wen),
        .lb_waddr           (lb_waddr),
        .lb_wdata           (lb_wdata),
        .mov_busy           (mov_busy),
        .mov_done           (mov_done),
        .mov_go_err         (mov_go_err)
    );

    function automatic logic [63:0] data_of(input logic [12:0] a);
        return {32'hCAFE_0000, 19'h0, a};
    endfunction

    // GB responder: fixed latency, in order.
    typedef struct { int due; logic [12:0] addr; } pend_t;
    pend_t pend[$];
    int cyc = 0;
    int lat = 1;

    always @(posedge clk) begin
        if (gb_rd_req && gnt) pend.push_back('{cyc + lat, gb_rd_addr});
        m_rvld <= 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            m_rvld  <= 1'b1;
            m_rdata <= data_of(pend[0].addr);
            void'(pend.pop_front());
        end
        cyc <= cyc + 1;
    end

    // Traffic monitor.
    typedef struct { logic [10:0] a; logic [63:0] d; } wr_t;
    logic [12:0] rd_log[$];
    wr_t         wr_log[$];
    int done_cnt = 0, err_cnt = 0, outs_tb = 0, max_outs = 0;
    logic clr = 1'b0;

    always @(negedge clk) begin
        int nxt;
        if (clr) begin
            rd_log.delete();
            wr_log.delete();
            done_cnt <= 0;
            err_cnt  <= 0;
            outs_tb  <= 0;
            max_outs <= 0;
        end else begin
            nxt = outs_tb;
            if (gb_rvld && outs_tb > 0) nxt = nxt - 1;
            if (gb_rd_req && gnt) begin
                rd_log.push_back(gb_rd_addr);
                nxt = nxt + 1;
            end
            outs_tb <= nxt;
            if (nxt > max_outs) max_outs <= nxt;
            if (lb_wen) wr_log.push_back('{lb_waddr, lb_wdata});
            if (mov_done) done_cnt <= done_cnt + 1;
            if (mov_go_err) err_cnt <= err_cnt + 1;
        end
    end

    int n_tests = 0, n_fail = 0;
    logic [12:0] exp_rd[$];
    logic [10:0] exp_wr[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 of the LOAD cycle.
    task automatic start(input logic [12:0] ga, input logic [12:0] gs,
                         input logic [10:0] la, input logic [5:0] ls,
                         input logic [12:0] ln, input logic [5:0] it);
        s_ga = ga; s_gs = gs; s_la = la; s_ls = ls; s_len = ln; s_it = it;
        go = 1'b1;
        clr = 1'b1;
        @(negedge clk); #1 clr = 1'b0;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_idle"}, 64'(mov_busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_rd_count"}, 64'(rd_log.size()), 64'(exp_rd.size()));
        chk({tag, "_wr_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int k = 0; k < exp_rd.size(); k++)
            chk($sformatf("%s_rd%0d", tag, k),
                (k < rd_log.size()) ? 64'(rd_log[k]) : 64'hDEAD_BEEF, 64'(exp_rd[k]));
        for (int k = 0; k < exp_wr.size(); k++) begin
            chk($sformatf("%s_wa%0d", tag, k),
                (k < wr_log.size()) ? 64'(wr_log[k].a) : 64'hDEAD_BEEF, 64'(exp_wr[k]));
            chk($sformatf("%s_wd%0d", tag, k),
                (k < wr_log.size()) ? wr_log[k].d : 64'hDEAD_BEEF, data_of(exp_rd[k]));
        end
    endtask

    task automatic set_basic_exp();
        exp_rd = '{13'h10, 13'h11, 13'h12, 13'h30, 13'h31, 13'h32};
        exp_wr = '{11'h5, 11'h6, 11'h7, 11'hD, 11'hE, 11'hF};
    endtask

    initial begin
        int n;
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",    64'(gb_rd_req),  64'd0);
        chk("rst_wen",    64'(lb_wen),     64'd0);
        chk("rst_busy",   64'(mov_busy),   64'd0);
        chk("rst_done",   64'(mov_done),   64'd0);
        chk("rst_goerr",  64'(mov_go_err), 64'd0);
        chk("rst_gaddr",  64'(gb_rd_addr), 64'd0);
        chk("rst_laddr",  64'(lb_waddr),   64'd0);
        chk("rst_ldata",  lb_wdata,        64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Stray return with nothing outstanding must not write LB
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_no_wen", 64'(lb_wen), 64'd0);
        @(posedge clk); #1;

        // Basic move, latency 1
        lat = 1;
        set_basic_exp();
        start(13'h10, 13'h20, 11'h5, 6'd8, 13'd3, 6'd2);
        @(negedge clk);
        chk("bm_busy", 64'(mov_busy), 64'd1);
        wait_done("bm", 200);
        check_logs("bm");

        // Back-pressure: latency 10, outstanding limit 4
        lat = 10;
        start(13'h200, 13'h0, 11'h40, 6'd0, 13'd8, 6'd1);
        n = 0;
        while (rd_log.size() < 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("bp_req_drop", 64'(gb_rd_req), 64'd0);
        chk("bp_rd4", 64'(rd_log.size()), 64'd4);
        wait_done("bp", 300);
        exp_rd = '{13'h200, 13'h201, 13'h202, 13'h203, 13'h204, 13'h205, 13'h206, 13'h207};
        exp_wr = '{11'h40, 11'h41, 11'h42, 11'h43, 11'h44, 11'h45, 11'h46, 11'h47};
        check_logs("bp");
        chk("bp_max_outs", 64'(max_outs), 64'd4);

        // Zero length: done two cycles after go, no traffic
        lat = 1;
        start(13'h10, 13'h20, 11'h5, 6'd8, 13'd0, 6'd5);
        @(negedge clk);
        chk("z_load_nodone", 64'(mov_done), 64'd0);
        chk("z_load_busy",   64'(mov_busy), 64'd1);
        @(negedge clk);
        chk("z_done",        64'(mov_done), 64'd1);
        @(negedge clk);
        chk("z_after_done",  64'(mov_done), 64'd0);
        chk("z_after_busy",  64'(mov_busy), 64'd0);
        chk("z_no_rd", 64'(rd_log.size()), 64'd0);
        chk("z_no_wr", 64'(wr_log.size()), 64'd0);
        @(posedge clk); #1;

        // Address wrap on both sides
        lat = 3;
        start(13'h1FFE, 13'h0, 11'h7FF, 6'd0, 13'd4, 6'd1);
        wait_done("wr", 200);
        exp_rd = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        exp_wr = '{11'h7FF, 11'h000, 11'h001, 11'h002};
        check_logs("wr");

        // go while RUN: flagged, move unaffected
        lat = 1;
        set_basic_exp();
        start(13'h10, 13'h20, 11'h5, 6'd8, 13'd3, 6'd2);
        @(negedge clk);
        @(posedge clk); #1;
        s_ga = 13'h400; s_len = 13'd1; s_it = 6'd1;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        chk("gr_err_pulse", 64'(mov_go_err), 64'd1);
        wait_done("gr", 200);
        check_logs("gr");
        chk("gr_err_once", 64'(err_cnt), 64'd1);

        // Reset in DRAIN, then a clean move
        lat = 10;
        start(13'h100, 13'h0, 11'h20, 6'd0, 13'd4, 6'd1);
        n = 0;
        while (rd_log.size() < 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("rd_in_drain_busy", 64'(mov_busy), 64'd1);
        chk("rd_in_drain_req",  64'(gb_rd_req), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rd_busy",  64'(mov_busy),   64'd0);
        chk("rd_req",   64'(gb_rd_req),  64'd0);
        chk("rd_wen",   64'(lb_wen),     64'd0);
        chk("rd_gaddr", 64'(gb_rd_addr), 64'd0);
        chk("rd_laddr", 64'(lb_waddr),   64'd0);
        chk("rd_ldata", lb_wdata,        64'd0);
        chk("rd_done",  64'(mov_done),   64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rd_no_stale_wr", 64'(wr_log.size()), 64'd0);
        chk("rd_no_done",     64'(done_cnt),      64'd0);
        @(posedge clk); #1;
        lat = 1;
        set_basic_exp();
        start(13'h10, 13'h20, 11'h5, 6'd8, 13'd3, 6'd2);
        wait_done("ra", 200);
        check_logs("ra");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dla_gb2lb_mov_ctrl.md
DLA_GB2LB_MOV_CTRL -- requirements
Module: dla_gb2lb_mov_ctrl

Interface
REQ-001 SHALL have parameter DW, default 64: GB/LB data width in bits.
REQ-002 SHALL have parameter MAX_OUTS, default 4: maximum outstanding GB reads, 1..15.
REQ-003 SHALL have ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- go_mov_gb2lb, input, 1: one-cycle start pulse; staging registers update on the same edge.
- stgr_gb2lb_gb_addr, input, 13: GB base address.
- stgr_gb2lb_gb_skip, input, 13: GB stride per iteration.
- stgr_gb2lb_lb_addr, input, 11: LB base address.
- stgr_gb2lb_lb_skip, input, 6: LB stride per iteration.
- stgr_gb2lb_len, input, 13: words per iteration.
- stgr_gb2lb_iter, input, 6: iteration count.
- gb_rd_req, output, 1: GB read request.
- gb_rd_addr, output, 13: GB read address.
- gb_rd_gnt, input, 1: GB accepts the request this cycle.
- gb_rvld, input, 1: GB read data valid; returns in request order, any latency >=1.
- gb_rdata, input, DW: GB read data.
- lb_wen, output, 1: LB write enable.
- lb_waddr, output, 11: LB write address.
- lb_wdata, output, DW: LB write data.
- mov_busy, output, 1: move in progress.
- mov_done, output, 1: one-cycle completion pulse.
- mov_go_err, output, 1: one-cycle pulse, go received while not IDLE.

Function
REQ-004 SHALL implement FSM IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
REQ-005 IDLE: go_mov_gb2lb=1 -> LOAD; otherwise stay.
REQ-006 LOAD, exactly one cycle: SHALL copy all stgr_* inputs into working registers and clear counters.
- len==0 or iter==0 -> DONE.
- Otherwise -> RUN.
REQ-007 Read address for word j of iteration i SHALL be (gb_base + i*gb_skip + j) mod 2^13, generated incrementally. No multiplier.
REQ-008 Write address for the same word SHALL be (lb_base + i*lb_skip + j) mod 2^11, generated incrementally on the write side.
REQ-009 RUN: gb_rd_req SHALL be 1 iff outstanding count < MAX_OUTS. gb_rd_addr is held stable until gb_rd_gnt.
REQ-010 Read handshake SHALL complete on gb_rd_req && gb_rd_gnt. The read counter then advances: j+1, or j=0, i+1 at j==len-1.
REQ-011 After the final read handshake, the FSM SHALL go to DRAIN and gb_rd_req SHALL be 0.
REQ-012 Outstanding count: +1 on handshake, -1 on gb_rvld, unchanged when both occur in the same cycle. Width ceil(log2(MAX_OUTS+1)).
REQ-013 Each gb_rvld SHALL produce lb_wen=1 on the next cycle with registered lb_waddr and lb_wdata=gb_rdata. Latency 1; no back-pressure on LB.
REQ-014 DRAIN -> DONE SHALL occur when all len*iter write beats are issued and the outstanding count is 0.
REQ-015 DONE SHALL pulse mov_done=1 for one cycle, then go to IDLE.
REQ-016 mov_busy SHALL be 1 in LOAD, RUN, DRAIN and DONE.
REQ-017 go_mov_gb2lb in any state other than IDLE SHALL be ignored, pulse mov_go_err the next cycle, and leave the move unaffected.
REQ-018 gb_rvld while outstanding==0 is a protocol error; it SHALL be ignored with no LB write (assertion in bench).
REQ-019 Total-beat counters SHALL be 19 bits: max 8191*63.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- state IDLE;
- all counters and working registers 0;
- gb_rd_req, lb_wen, mov_busy, mov_done, mov_go_err = 0;
- gb_rd_addr, lb_waddr, lb_wdata = 0.
REQ-021 Reset mid-move SHALL abort immediately; in-flight GB data arriving after reset release is ignored per REQ-018.

Structure
REQ-022 FSM state enum (IDLE, LOAD, RUN, DRAIN, DONE) SHALL live in PKG_dla_regmap, next to the GB2LB register typedefs.
REQ-023 A sub-module dla_gb2lb_addr_gen SHALL be instantiated twice, once for the read side (13b) and once for the write side (11b). It holds the (i,j) counters and the address accumulator, with ports base, skip, len, iter, load, step, addr, last.

Verification
REQ-024 Basic move: gb_addr=0x10, gb_skip=0x20, lb_addr=0x5, lb_skip=8, len=3, iter=2, gnt tied 1, read latency 1.
-> GB reads 0x10,0x11,0x12,0x30,0x31,0x32.
-> LB writes 0x5,0x6,0x7,0xD,0xE,0xF with matching data.
-> mov_done exactly once.
REQ-025 Back-pressure: len=8, iter=1, latency 10 cycles.
-> gb_rd_req drops after 4 handshakes.
-> Outstanding never exceeds 4.
-> 8 LB writes issued.
REQ-026 Zero length: len=0, iter=5.
-> No gb_rd_req, no lb_wen.
-> mov_done 2 cycles after go.
REQ-027 Wrap: gb_addr=0x1FFE, len=4, lb_addr=0x7FF.
-> GB addresses 0x1FFE,0x1FFF,0x0000,0x0001.
-> LB addresses 0x7FF,0x000,0x001,0x002.
REQ-028 go during RUN -> mov_go_err pulse, original transfer completes unchanged.
REQ-029 rst_n low during DRAIN -> all outputs 0 immediately; a subsequent go completes correctly.
